// File: rtl/ram_burst_master_pkg.sv
// ram_burst_master_pkg
// Shared definitions for the RAM burst master: FSM state encoding, default
// widths and the read-issue admission helper.
package ram_burst_master_pkg;

  localparam int DEF_ADDRESS_WIDTH = 4;
  localparam int DEF_DATA_WIDTH    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  // A read may be issued only if the word it returns next cycle will find a
  // free FIFO slot: occupancy plus the word already in flight, minus the word
  // leaving this cycle, must stay below the 2-entry depth.
  function automatic logic read_room(input logic [1:0] count,
                                     input logic       inflight,
                                     input logic       pop);
    logic [2:0] w_level;
    w_level = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    return (w_level < 3'd2);
  endfunction

endpackage

// File: rtl/ram_burst_master_read_fifo.sv
// ram_burst_master_read_fifo
// Two-entry synchronous FIFO that buffers RAM read data for the output stream.
// Ports:
//   Clock, Reset   - clock, asynchronous active-low reset
//   i_push, i_data - write side (word returned by the RAM)
//   i_pop          - read side handshake (ignored when empty)
//   o_count        - current occupancy 0..2
//   o_valid        - FIFO holds at least one word
//   o_data         - head word; holds the last popped word while empty
module ram_burst_master_read_fifo #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [1:0]            o_count,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] r_mem [0:1];
  logic [DATA_WIDTH-1:0] r_last;
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;
  logic                  w_pop;
  logic                  w_push;

  assign w_pop  = i_pop & (r_count != 2'd0);
  assign w_push = i_push & (~r_count[1] | w_pop);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_last  <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_last <= r_mem[r_rptr];
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_valid = (r_count != 2'd0);
  // Once drained, keep presenting the last word handed out.
  assign o_data  = o_valid ? r_mem[r_rptr] : r_last;

endmodule

// File: rtl/ram_burst_master.sv
// ram_burst_master
// Burst initiator for a single-port synchronous RAM. Accepts one command at a
// time (write/read, start address, length). Write bursts stream WrData_i into
// the RAM; read bursts stream RAM words out through a 2-entry FIFO with full
// backpressure. Addresses wrap modulo 2^ADDRESS_WIDTH.
// Ports:
//   Clock, Reset                    - clock, asynchronous active-low reset
//   CmdValid_i/CmdReady_o           - command handshake
//   CmdWrite_i, CmdAddress_i,
//   CmdLength_i                     - command fields (length 0 = no-op)
//   WrValid_i/WrReady_o, WrData_i   - write data stream
//   RdValid_o/RdReady_i, RdData_o   - read data stream
//   Busy_o, Done_o                  - burst in progress / completion pulse
//   RamReadEnable_o, RamWriteEnable_o,
//   RamAddress_o, RamData_o, RamData_i - RAM interface
module ram_burst_master
  import ram_burst_master_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int LENGTH_WIDTH  = ADDRESS_WIDTH + 1
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     CmdValid_i,
  output logic                     CmdReady_o,
  input  logic                     CmdWrite_i,
  input  logic [ADDRESS_WIDTH-1:0] CmdAddress_i,
  input  logic [LENGTH_WIDTH-1:0]  CmdLength_i,
  input  logic                     WrValid_i,
  output logic                     WrReady_o,
  input  logic [DATA_WIDTH-1:0]    WrData_i,
  output logic                     RdValid_o,
  input  logic                     RdReady_i,
  output logic [DATA_WIDTH-1:0]    RdData_o,
  output logic                     Busy_o,
  output logic                     Done_o,
  output logic                     RamReadEnable_o,
  output logic                     RamWriteEnable_o,
  output logic [ADDRESS_WIDTH-1:0] RamAddress_o,
  output logic [DATA_WIDTH-1:0]    RamData_o,
  input  logic [DATA_WIDTH-1:0]    RamData_i
);

  state_t                   r_state;
  state_t                   w_next;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [LENGTH_WIDTH-1:0]  r_remain;
  logic                     r_inflight;
  logic                     r_done;
  logic [1:0]               w_fifo_count;
  logic                     w_cmd_acc;
  logic                     w_wr_xfer;
  logic                     w_pop;
  logic                     w_issue;
  logic                     w_wr_last;
  logic                     w_rd_last;

  assign w_cmd_acc = CmdValid_i & Reset & (r_state == ST_IDLE);
  assign w_wr_xfer = (r_state == ST_WRITE) & WrValid_i;
  assign w_pop     = RdValid_o & RdReady_i;
  assign w_issue   = (r_state == ST_READ) & (r_remain != '0) &
                     read_room(w_fifo_count, r_inflight, w_pop);
  assign w_wr_last = w_wr_xfer & (r_remain == LENGTH_WIDTH'(1));
  // Read burst ends on the pop of the final word: nothing left to issue,
  // nothing in flight, one word left in the FIFO.
  assign w_rd_last = (r_state == ST_READ) & (r_remain == '0) & ~r_inflight &
                     (w_fifo_count == 2'd1) & w_pop;

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_cmd_acc && (CmdLength_i != '0))
                  w_next = CmdWrite_i ? ST_WRITE : ST_READ;
      ST_WRITE: if (w_wr_last) w_next = ST_IDLE;
      ST_READ:  if (w_rd_last) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    CmdReady_o       = Reset & (r_state == ST_IDLE);
    WrReady_o        = (r_state == ST_WRITE);
    Busy_o           = (r_state != ST_IDLE);
    RamWriteEnable_o = w_wr_xfer;
    RamReadEnable_o  = w_issue;
    RamData_o        = (r_state == ST_WRITE) ? WrData_i : '0;
    RamAddress_o     = r_addr;
    Done_o           = r_done;
  end

  // Address/count tracking and completion pulse
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_addr     <= '0;
      r_remain   <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= (w_cmd_acc && (CmdLength_i == '0)) | w_wr_last | w_rd_last;
      r_inflight <= w_issue;
      if (w_cmd_acc) begin
        r_addr   <= CmdAddress_i;
        r_remain <= CmdLength_i;
      end else if (w_wr_xfer || w_issue) begin
        r_addr   <= r_addr + ADDRESS_WIDTH'(1);
        r_remain <= r_remain - LENGTH_WIDTH'(1);
      end
    end
  end

  // Word read last cycle is captured as it comes out of the RAM.
  ram_burst_master_read_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_read_fifo (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_push  (r_inflight),
    .i_data  (RamData_i),
    .i_pop   (w_pop),
    .o_count (w_fifo_count),
    .o_valid (RdValid_o),
    .o_data  (RdData_o)
  );

endmodule

// File: tb/tb_ram_burst_master.sv
module tb_ram_burst_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       CmdValid_i, CmdReady_o, CmdWrite_i;
  logic [3:0] CmdAddress_i;
  logic [4:0] CmdLength_i;
  logic       WrValid_i, WrReady_o;
  logic [7:0] WrData_i;
  logic       RdValid_o, RdReady_i;
  logic [7:0] RdData_o;
  logic       Busy_o, Done_o;
  logic       RamReadEnable_o, RamWriteEnable_o;
  logic [3:0] RamAddress_o;
  logic [7:0] RamData_o, RamData_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_burst_master dut (
    .Clock(clk), .Reset(rst_n),
    .CmdValid_i(CmdValid_i), .CmdReady_o(CmdReady_o), .CmdWrite_i(CmdWrite_i),
    .CmdAddress_i(CmdAddress_i), .CmdLength_i(CmdLength_i),
    .WrValid_i(WrValid_i), .WrReady_o(WrReady_o), .WrData_i(WrData_i),
    .RdValid_o(RdValid_o), .RdReady_i(RdReady_i), .RdData_o(RdData_o),
    .Busy_o(Busy_o), .Done_o(Done_o),
    .RamReadEnable_o(RamReadEnable_o), .RamWriteEnable_o(RamWriteEnable_o),
    .RamAddress_o(RamAddress_o), .RamData_o(RamData_o), .RamData_i(RamData_i)
  );

  // Behavioural single-port synchronous RAM, one-cycle read latency.
  logic [7:0] ram [0:15];
  logic [7:0] ram_q;
  always @(posedge clk) begin
    if (RamWriteEnable_o) ram[RamAddress_o] <= RamData_o;
    if (RamReadEnable_o)  ram_q <= ram[RamAddress_o];
  end
  assign RamData_i = ram_q;

  typedef struct packed {
    logic       wv;
    logic [7:0] wd;
    logic       rr;
    logic       e_we;
    logic       e_re;
    logic [3:0] e_addr;
    logic [7:0] e_wdat;
    logic       e_wrdy;
    logic       e_rv;
    logic [7:0] e_rd;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t tw [6];
  vec_t tr [8];
  vec_t tg [8];
  logic [7:0] exp6 [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [3:0] a, input logic [4:0] l);
    CmdValid_i = 1'b1; CmdWrite_i = w; CmdAddress_i = a; CmdLength_i = l;
    @(negedge clk);
    chk("cmd_ready", CmdReady_o, 1);
    tick();
    CmdValid_i = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input string tag, input int i);
    WrValid_i = v.wv; WrData_i = v.wd; RdReady_i = v.rr;
    @(negedge clk);
    chk($sformatf("%s[%0d] we", tag, i), RamWriteEnable_o, v.e_we);
    chk($sformatf("%s[%0d] re", tag, i), RamReadEnable_o, v.e_re);
    if (v.e_we || v.e_re) chk($sformatf("%s[%0d] addr", tag, i), RamAddress_o, v.e_addr);
    if (v.e_we) chk($sformatf("%s[%0d] wdata", tag, i), RamData_o, v.e_wdat);
    chk($sformatf("%s[%0d] wrready", tag, i), WrReady_o, v.e_wrdy);
    chk($sformatf("%s[%0d] rdvalid", tag, i), RdValid_o, v.e_rv);
    chk($sformatf("%s[%0d] rddata", tag, i), RdData_o, v.e_rd);
    chk($sformatf("%s[%0d] busy", tag, i), Busy_o, v.e_busy);
    chk($sformatf("%s[%0d] done", tag, i), Done_o, v.e_done);
    chk($sformatf("%s[%0d] cmdready", tag, i), CmdReady_o, !v.e_busy);
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " cmdready"}, CmdReady_o, 0);
    chk({tag, " busy"}, Busy_o, 0);
    chk({tag, " done"}, Done_o, 0);
    chk({tag, " re"}, RamReadEnable_o, 0);
    chk({tag, " we"}, RamWriteEnable_o, 0);
    chk({tag, " wrready"}, WrReady_o, 0);
    chk({tag, " rdvalid"}, RdValid_o, 0);
    chk({tag, " rddata"}, RdData_o, 0);
    chk({tag, " addr"}, RamAddress_o, 0);
    chk({tag, " ramdata"}, RamData_o, 0);
  endtask

  initial begin
    int   got, occ, maxocc, viol, stray;
    logic inflight, pop, done_seen;

    //          wv    wd     rr    we    re    addr   wdat   wrdy  rv    rd     busy  done
    tw[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 4'hE, 8'h11, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tw[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 4'hF, 8'h22, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tw[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 4'h0, 8'h33, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tw[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 4'h1, 8'h44, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tw[4] = '{1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    tw[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    tr[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'hE, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tr[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'hF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tr[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'h0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0};
    tr[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'h1, 8'h00, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0};
    tr[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0};
    tr[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 8'h44, 1'b1, 1'b0};
    tr[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h44, 1'b0, 1'b1};
    tr[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0};

    tg[0] = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 4'h2, 8'hA1, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0};
    tg[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0};
    tg[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0};
    tg[3] = '{1'b1, 8'hB2, 1'b0, 1'b1, 1'b0, 4'h3, 8'hB2, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0};
    tg[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0};
    tg[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0};
    tg[6] = '{1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 4'h4, 8'hC3, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0};
    tg[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h44, 1'b0, 1'b1};

    exp6[0] = 8'h11; exp6[1] = 8'h22; exp6[2] = 8'h33;
    exp6[3] = 8'h44; exp6[4] = 8'hA1; exp6[5] = 8'hB2;

    // Reset state, with stray write activity offered
    rst_n = 1'b0;
    CmdValid_i = 1'b0; CmdWrite_i = 1'b0; CmdAddress_i = 4'h0; CmdLength_i = 5'd0;
    WrValid_i = 1'b1; WrData_i = 8'h5A; RdReady_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    #2 rst_n = 1'b1;
    tick();
    WrValid_i = 1'b0;

    // Write burst with address wrap
    send_cmd(1'b1, 4'hE, 5'd4);
    for (int i = 0; i < 6; i++) apply_vec(tw[i], "wr4", i);

    // Read burst back, consumer always ready
    send_cmd(1'b0, 4'hE, 5'd4);
    for (int i = 0; i < 8; i++) apply_vec(tr[i], "rd4", i);

    // Write burst with 2-cycle valid gaps
    send_cmd(1'b1, 4'h2, 5'd3);
    for (int i = 0; i < 8; i++) apply_vec(tg[i], "wrgap", i);

    // Read burst of 6 under toggling backpressure
    WrValid_i = 1'b0;
    send_cmd(1'b0, 4'hE, 5'd6);
    got = 0; occ = 0; maxocc = 0; viol = 0; inflight = 1'b0; done_seen = 1'b0;
    for (int c = 0; c < 80 && !done_seen; c++) begin
      RdReady_i = ((c % 3) == 0);
      @(negedge clk);
      pop = RdValid_o & RdReady_i;
      if (RamReadEnable_o && RamWriteEnable_o) viol++;
      if (RdValid_o !== (occ > 0)) viol++;
      if (RamReadEnable_o && (occ + int'(inflight) - int'(pop) >= 2)) viol++;
      if (pop) begin
        if (got < 6) chk($sformatf("rd6 word%0d", got), RdData_o, exp6[got]);
        got++;
      end
      if (Done_o) done_seen = 1'b1;
      occ = occ + int'(inflight) - int'(pop);
      inflight = RamReadEnable_o;
      if (occ > maxocc) maxocc = occ;
      tick();
    end
    chk("rd6 done_seen", done_seen, 1);
    chk("rd6 word_count", got, 6);
    chk("rd6 occupancy_le2", (maxocc <= 2), 1);
    chk("rd6 protocol_violations", viol, 0);
    @(negedge clk);
    chk("rd6 done_single", Done_o, 0);
    chk("rd6 rddata_hold", RdData_o, 8'hB2);
    tick();

    // Zero-length command
    RdReady_i = 1'b1;
    send_cmd(1'b0, 4'h3, 5'd0);
    @(negedge clk);
    chk("len0 done", Done_o, 1);
    chk("len0 busy", Busy_o, 0);
    chk("len0 re", RamReadEnable_o, 0);
    chk("len0 we", RamWriteEnable_o, 0);
    chk("len0 cmdready", CmdReady_o, 1);
    tick();
    @(negedge clk);
    chk("len0 done_clear", Done_o, 0);
    tick();

    // Reset during the second word of a length-5 read
    send_cmd(1'b0, 4'hE, 5'd5);
    tick();
    @(negedge clk);
    chk("midrst second_issue", RamReadEnable_o, 1);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst_async");
    tick();
    @(negedge clk);
    chk_reset_outputs("midrst_held");
    #2 rst_n = 1'b1;
    tick();
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (Done_o || Busy_o || RamReadEnable_o || RamWriteEnable_o || RdValid_o) stray++;
      tick();
    end
    chk("midrst no_activity", stray, 0);

    // New commands accepted after release
    send_cmd(1'b1, 4'h7, 5'd1);
    WrValid_i = 1'b1; WrData_i = 8'h77;
    @(negedge clk);
    chk("post wr we", RamWriteEnable_o, 1);
    chk("post wr addr", RamAddress_o, 4'h7);
    chk("post wr data", RamData_o, 8'h77);
    tick();
    WrValid_i = 1'b0;
    @(negedge clk);
    chk("post wr done", Done_o, 1);
    tick();
    send_cmd(1'b0, 4'h7, 5'd1);
    @(negedge clk);
    chk("post rd re", RamReadEnable_o, 1);
    chk("post rd addr", RamAddress_o, 4'h7);
    tick();
    @(negedge clk);
    chk("post rd no_early_valid", RdValid_o, 0);
    tick();
    @(negedge clk);
    chk("post rd valid", RdValid_o, 1);
    chk("post rd data", RdData_o, 8'h77);
    tick();
    @(negedge clk);
    chk("post rd done", Done_o, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_burst_master.md
Name: ram_burst_master

Overview:
- Initiator for the single-port synchronous RAM. It accepts one burst command at a time: operation, start address and length.
- Write bursts move words from a valid/ready input stream into the RAM. Read bursts move RAM words to a valid/ready output stream with full backpressure.
- It sits between stream producers/consumers (UART, DMA) and the RAM block. It owns every RAM port except Clock and Reset.

Parameters:
- ADDRESS_WIDTH, 4, RAM address width; addresses wrap modulo 2^ADDRESS_WIDTH.
- DATA_WIDTH, 8, word width.
- LENGTH_WIDTH, ADDRESS_WIDTH+1, burst length field width; maximum burst is 2^LENGTH_WIDTH-1 words.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low; Reset=0 clears all state.
- CmdValid_i  in  1  command offered.
- CmdReady_o  out  1  command accepted when CmdValid_i&CmdReady_o.
- CmdWrite_i  in  1  1=write burst, 0=read burst.
- CmdAddress_i  in  ADDRESS_WIDTH  start address.
- CmdLength_i  in  LENGTH_WIDTH  number of words; 0 = no-op.
- WrValid_i  in  1  write word offered.
- WrReady_o  out  1  write word consumed on WrValid_i&WrReady_o.
- WrData_i  in  DATA_WIDTH  write word.
- RdValid_o  out  1  read word available.
- RdReady_i  in  1  consumer takes word on RdValid_o&RdReady_i.
- RdData_o  out  DATA_WIDTH  read word.
- Busy_o  out  1  burst in progress.
- Done_o  out  1  one-cycle pulse at burst completion.
- RamReadEnable_o  out  1  to RAM ReadEnable_i.
- RamWriteEnable_o  out  1  to RAM WriteEnable_i.
- RamAddress_o  out  ADDRESS_WIDTH  to RAM Address_i.
- RamData_o  out  DATA_WIDTH  to RAM Data_i.
- RamData_i  in  DATA_WIDTH  from RAM Data_o; valid the cycle after RamReadEnable_o=1.

Behaviour:
- Reset values: all outputs 0, except CmdReady_o=1 once Reset=1 (IDLE). State returns to IDLE, buffer is emptied, counters are 0.
- Reset mid-burst: the burst is abandoned immediately. No RAM enable is asserted afterwards and no Done_o pulse is produced.
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - CmdReady_o=1.
  - On accept with length≠0: latch address and remaining count; go to WRITE or READ.
  - On accept with length=0: stay IDLE; Done_o=1 on the next cycle.
- WRITE:
  - CmdReady_o=0; WrReady_o=1.
  - RamWriteEnable_o = WrValid_i (combinational); RamAddress_o = address counter; RamData_o = WrData_i.
  - Each transfer increments the address (wrapping) and decrements the count.
  - After the final transfer: go to IDLE; Done_o=1 the following cycle.
  - WrValid_i gaps stall the burst with no RAM activity.
- READ:
  - Data lands in a 2-entry FIFO that drives RdValid_o/RdData_o.
  - A read is issued (RamReadEnable_o=1) only when words remain to issue and occupancy + in-flight − pop_this_cycle < 2.
  - The in-flight word is written into the FIFO the cycle after issue.
  - With RdReady_i held high: one word per cycle sustained. The first RdValid_o appears 2 cycles after the first RamReadEnable_o.
  - With RdReady_i low: no words are lost and RamReadEnable_o stops within one cycle.
  - Completion = all words issued and the FIFO drained. Then go to IDLE; Done_o=1 the next cycle.
- RAM enables are never both asserted. RamReadEnable_o=0 outside READ; RamWriteEnable_o=0 outside WRITE.
- Busy_o=1 in WRITE and READ.
- WrReady_o=0 outside WRITE. WrData_i is ignored unless a transfer occurs.
- RdData_o holds its last value when RdValid_o=0.
- A command offered while busy is not accepted; it must be held until CmdReady_o=1.

Decomposition:
- Shared include ram_master_defs.vh: state encodings (IDLE=2'd0, WRITE=2'd1, READ=2'd2) and the default widths.
- One sub-module, ram_read_fifo: 2-entry synchronous FIFO with push, pop, count, valid; same Clock/Reset.

Test Plan:
- Write burst, addr 0xE, length 4, data 11,22,33,44, WrValid_i continuous:
  - RAM writes 0xE=11, 0xF=22, 0x0=33, 0x1=44 (address wrap).
  - Single Done_o pulse; Busy_o low afterwards.
- Read burst, addr 0xE, length 4, RdReady_i=1:
  - RdData_o = 11,22,33,44 on consecutive cycles.
  - First RdValid_o 2 cycles after the first RamReadEnable_o.
- Read burst, length 6, RdReady_i toggling 1,0,0,1,…:
  - All 6 words arrive in order, none duplicated or dropped.
  - FIFO never exceeds 2 entries.
- Write burst, length 3, WrValid_i with 2-cycle gaps:
  - RamWriteEnable_o asserts only on valid cycles; correct addresses written.
- Command with length 0:
  - Done_o pulses the next cycle; no RAM enables asserted.
- Reset=0 during the 2nd word of a length-5 read:
  - All outputs return to reset values, no Done_o pulse.
  - After release, a new command is accepted.
